// File: rtl/wdt_pkg.sv
// wdt_pkg: shared definitions for the watchdog timer.
//   wdt_state_t     - FSM state encoding (RESET_REQ only with WDT_RESET_REQ_EN)
//   WDT_WDEN..WDCNT - register addresses on wdt_addr
//   WDT_WTOCNT_RST  - value loaded into the timeout register by reset
package wdt_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNT     = 2'd1,
        TIMEOUT   = 2'd2
`ifdef WDT_RESET_REQ_EN
        ,
        RESET_REQ = 2'd3
`endif
    } wdt_state_t;

    localparam logic [1:0] WDT_WDEN   = 2'd0;
    localparam logic [1:0] WDT_WDLIVE = 2'd1;
    localparam logic [1:0] WDT_WTOCNT = 2'd2;
    localparam logic [1:0] WDT_WDCNT  = 2'd3;

    localparam logic [31:0] WDT_WTOCNT_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/wdt_counter.sv
// wdt_counter: CNT_W-bit up-counter with synchronous clear and enable, and an
// equality compare against cmp_val.
//   clk, rst     - clock, asynchronous active-low reset
//   clr          - clear to 0 on next edge (wins over en)
//   en           - increment on next edge
//   cmp_val      - compare value
//   cnt          - current count
//   match        - cnt == cmp_val (combinational)
module wdt_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] cmp_val,
    output logic [CNT_W-1:0] cnt,
    output logic             match
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            // Plain modular increment: wrapping to 0 has no side effect.
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign match = (cnt == cmp_val);

endmodule

// File: rtl/wdt_timer.sv
// wdt_timer: watchdog timer with a 4-entry register window.
//   clk, rst       - clock, asynchronous active-low reset
//   wdt_we         - register write strobe
//   wdt_addr       - 0 WDEN, 1 WDLIVE (kick), 2 WTOCNT, 3 WDCNT (read-only)
//   wdt_wdata      - write data (WDEN/WDLIVE use bit 0)
//   wdt_rdata      - combinational read of wdt_addr
//   WDT_interrupt  - registered level timeout interrupt
//   wdt_rst_req    - registered second-stage reset request
// Build option WDT_RESET_REQ_EN: a second timeout while the interrupt is
// pending enters RESET_REQ and raises wdt_rst_req until rst. Without it the
// counter is held in TIMEOUT and wdt_rst_req is tied low.
module wdt_timer
    import wdt_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wdt_we,
    input  logic [1:0]  wdt_addr,
    input  logic [31:0] wdt_wdata,
    output logic [31:0] wdt_rdata,
    output logic        WDT_interrupt,
    output logic        wdt_rst_req
);

    wdt_state_t       state;
    logic [CNT_W-1:0] wtocnt;
    logic [CNT_W-1:0] cnt;
    logic             match;
    logic             cnt_clr;
    logic             cnt_en;
    logic             locked;
    logic             wr;
    logic             wden_on;
    logic             wden_off;
    logic             kick;

`ifdef WDT_RESET_REQ_EN
    assign locked = (state == RESET_REQ);
`else
    assign locked = 1'b0;
`endif

    // Once a reset has been requested, software can no longer intervene.
    assign wr       = wdt_we && !locked;
    assign wden_on  = wr && (wdt_addr == WDT_WDEN)   &&  wdt_wdata[0];
    assign wden_off = wr && (wdt_addr == WDT_WDEN)   && !wdt_wdata[0];
    assign kick     = wr && (wdt_addr == WDT_WDLIVE) &&  wdt_wdata[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wtocnt <= WDT_WTOCNT_RST[CNT_W-1:0];
        end else if (wr && (wdt_addr == WDT_WTOCNT)) begin
            wtocnt <= wdt_wdata[CNT_W-1:0];
        end
    end

    // Counter control. Any state transition out of COUNT/TIMEOUT clears the
    // count so the next phase starts from 0; a kick on the match cycle clears
    // it before the match can take effect.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state)
            IDLE:    cnt_clr = 1'b1;
            COUNT: begin
                if (wden_off || kick || match) cnt_clr = 1'b1;
                else                           cnt_en  = 1'b1;
            end
`ifdef WDT_RESET_REQ_EN
            TIMEOUT: begin
                if (wden_off || kick || match) cnt_clr = 1'b1;
                else                           cnt_en  = 1'b1;
            end
            RESET_REQ: ;
`else
            TIMEOUT: cnt_clr = 1'b1;
`endif
            default: cnt_clr = 1'b1;
        endcase
    end

    wdt_counter #(.CNT_W(CNT_W)) u_counter (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .cmp_val (wtocnt),
        .cnt     (cnt),
        .match   (match)
    );

`ifdef WDT_RESET_REQ_EN
    logic rst_req_q;
    assign wdt_rst_req = rst_req_q;
`else
    assign wdt_rst_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            WDT_interrupt <= 1'b0;
`ifdef WDT_RESET_REQ_EN
            rst_req_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (wden_on) state <= COUNT;
                end
                COUNT: begin
                    if (wden_off) begin
                        state <= IDLE;
                    end else if (!kick && match) begin
                        state         <= TIMEOUT;
                        WDT_interrupt <= 1'b1;
                    end
                end
                TIMEOUT: begin
                    if (wden_off) begin
                        state         <= IDLE;
                        WDT_interrupt <= 1'b0;
                    end else if (kick) begin
                        state         <= COUNT;
                        WDT_interrupt <= 1'b0;
                    end
`ifdef WDT_RESET_REQ_EN
                    else if (match) begin
                        state     <= RESET_REQ;
                        rst_req_q <= 1'b1;
                    end
`endif
                end
`ifdef WDT_RESET_REQ_EN
                RESET_REQ: ;
`endif
                default: begin
                    state         <= IDLE;
                    WDT_interrupt <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        wdt_rdata = 32'd0;
        case (wdt_addr)
            WDT_WDEN:   wdt_rdata = {31'd0, state != IDLE};
            WDT_WDLIVE: wdt_rdata = {31'd0, WDT_interrupt};
            WDT_WTOCNT: wdt_rdata = 32'(wtocnt);
            WDT_WDCNT:  wdt_rdata = 32'(cnt);
            default:    wdt_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_wdt_timer.sv
// tb_wdt_timer: scoreboard bench for wdt_timer. The stimulus process drives one
// cycle at a time and queues the outputs expected during that cycle; a monitor
// pops and compares on each falling edge (or immediately, for async reset).
module tb_wdt_timer;
    import wdt_pkg::*;

    logic        clk;
    logic        rst;
    logic        wdt_we;
    logic [1:0]  wdt_addr;
    logic [31:0] wdt_wdata;
    logic [31:0] wdt_rdata;
    logic        WDT_interrupt;
    logic        wdt_rst_req;

    wdt_timer #(.CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .wdt_we        (wdt_we),
        .wdt_addr      (wdt_addr),
        .wdt_wdata     (wdt_wdata),
        .wdt_rdata     (wdt_rdata),
        .WDT_interrupt (WDT_interrupt),
        .wdt_rst_req   (wdt_rst_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        chk_rd;
        logic [31:0] rd;
        logic        irq;
        logic        rrq;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    event sample_ev;

    // Monitor: one queued expectation per sample point.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or sample_ev);
            if (q.size() != 0) begin
                e = q.pop_front();
                total++;
                if ((e.chk_rd && (wdt_rdata !== e.rd)) ||
                    (WDT_interrupt !== e.irq) || (wdt_rst_req !== e.rrq)) begin
                    bad++;
                    $display("FAIL %s: rdata=%h irq=%b rst_req=%b, expected rdata=%h(chk=%b) irq=%b rst_req=%b",
                             e.name, wdt_rdata, WDT_interrupt, wdt_rst_req,
                             e.rd, e.chk_rd, e.irq, e.rrq);
                end
            end
        end
    end

    // Drive one cycle of inputs, queue the expected outputs for that cycle.
    task automatic cyc(input string nm, input logic we, input logic [1:0] a,
                       input logic [31:0] d, input logic chk_rd,
                       input logic [31:0] rd, input logic irq, input logic rrq);
        exp_t e;
        wdt_we    = we;
        wdt_addr  = a;
        wdt_wdata = d;
        e = '{nm, chk_rd, rd, irq, rrq};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input string nm, input logic [1:0] a, input logic [31:0] d,
                      input logic irq, input logic rrq);
        cyc(nm, 1'b1, a, d, 1'b0, 32'd0, irq, rrq);
    endtask

    task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] v,
                      input logic irq, input logic rrq);
        cyc(nm, 1'b0, a, 32'd0, 1'b1, v, irq, rrq);
    endtask

    // Short reset pulse placed inside the high clock phase: no edge occurs.
    task automatic rst_pulse(input string nm);
        exp_t e;
        wdt_we   = 1'b0;
        wdt_addr = WDT_WTOCNT;
        rst      = 1'b0;
        #1;
        e = '{nm, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        q.push_back(e);
        ->sample_ev;
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        wdt_we    = 1'b0;
        wdt_addr  = WDT_WTOCNT;
        wdt_wdata = 32'd0;
        @(posedge clk);
        #1;
        rd("rst_wtocnt", WDT_WTOCNT, 32'hFFFF_FFFF, 1'b0, 1'b0);
        rst = 1'b1;
        rd("rst_wden",  WDT_WDEN,  32'd0, 1'b0, 1'b0);
        rd("rst_wdcnt", WDT_WDCNT, 32'd0, 1'b0, 1'b0);

        // Plain timeout: WTOCNT=5, interrupt in cycle 7 after the enable write.
        wr("t1_wtocnt", WDT_WTOCNT, 32'd5, 1'b0, 1'b0);
        wr("t1_en", WDT_WDEN, 32'd1, 1'b0, 1'b0);
        for (int i = 0; i <= 5; i++) rd("t1_cnt", WDT_WDCNT, 32'(i), 1'b0, 1'b0);
        rd("t1_irq", WDT_WDLIVE, 32'd1, 1'b1, 1'b0);
        wr("t1_dis", WDT_WDEN, 32'd0, 1'b1, 1'b0);
        rd("t1_idle_en", WDT_WDEN, 32'd0, 1'b0, 1'b0);
        rd("t1_idle_irq", WDT_WDLIVE, 32'd0, 1'b0, 1'b0);

        // Kick on the match cycle wins.
        wr("t2_en", WDT_WDEN, 32'd1, 1'b0, 1'b0);
        for (int i = 0; i <= 4; i++) rd("t2_cnt", WDT_WDCNT, 32'(i), 1'b0, 1'b0);
        wr("t2_kick_on_match", WDT_WDLIVE, 32'd1, 1'b0, 1'b0);
        for (int i = 0; i <= 5; i++) rd("t2_cnt_after_kick", WDT_WDCNT, 32'(i), 1'b0, 1'b0);
        rd("t2_irq", WDT_WDLIVE, 32'd1, 1'b1, 1'b0);

        // Kick out of TIMEOUT, then disable out of TIMEOUT.
        wr("t3_kick", WDT_WDLIVE, 32'd1, 1'b1, 1'b0);
        rd("t3_cnt0", WDT_WDCNT, 32'd0, 1'b0, 1'b0);
        rd("t3_enabled", WDT_WDEN, 32'd1, 1'b0, 1'b0);
        for (int i = 2; i <= 5; i++) rd("t3_cnt", WDT_WDCNT, 32'(i), 1'b0, 1'b0);
        rd("t3_irq", WDT_WDLIVE, 32'd1, 1'b1, 1'b0);
        wr("t3_dis", WDT_WDEN, 32'd0, 1'b1, 1'b0);
        rd("t3_idle_en", WDT_WDEN, 32'd0, 1'b0, 1'b0);
        rd("t3_idle_cnt", WDT_WDCNT, 32'd0, 1'b0, 1'b0);

        // Kick in IDLE is ignored.
        wr("idle_kick", WDT_WDLIVE, 32'd1, 1'b0, 1'b0);
        rd("idle_kick_en", WDT_WDEN, 32'd0, 1'b0, 1'b0);
        rd("idle_kick_cnt", WDT_WDCNT, 32'd0, 1'b0, 1'b0);

        // WTOCNT=0: interrupt two cycles after enable; async reset clears it.
        wr("t4_wtocnt", WDT_WTOCNT, 32'd0, 1'b0, 1'b0);
        wr("t4_en", WDT_WDEN, 32'd1, 1'b0, 1'b0);
        rd("t4_cnt", WDT_WDCNT, 32'd0, 1'b0, 1'b0);
        rd("t4_irq", WDT_WDLIVE, 32'd1, 1'b1, 1'b0);
        rst_pulse("t4_async_rst");
        rd("t4_post_en", WDT_WDEN, 32'd0, 1'b0, 1'b0);
        rd("t4_post_wtocnt", WDT_WTOCNT, 32'hFFFF_FFFF, 1'b0, 1'b0);

`ifdef WDT_RESET_REQ_EN
        // Second timeout escalates to a reset request; writes then ignored.
        wr("t5_wtocnt", WDT_WTOCNT, 32'd3, 1'b0, 1'b0);
        wr("t5_en", WDT_WDEN, 32'd1, 1'b0, 1'b0);
        for (int i = 0; i <= 3; i++) rd("t5_cnt", WDT_WDCNT, 32'(i), 1'b0, 1'b0);
        for (int i = 0; i <= 3; i++) rd("t5_to_cnt", WDT_WDCNT, 32'(i), 1'b1, 1'b0);
        rd("t5_rrq", WDT_WDLIVE, 32'd1, 1'b1, 1'b1);
        wr("t5_kick_ignored", WDT_WDLIVE, 32'd1, 1'b1, 1'b1);
        wr("t5_dis_ignored", WDT_WDEN, 32'd0, 1'b1, 1'b1);
        wr("t5_wtocnt_ignored", WDT_WTOCNT, 32'd7, 1'b1, 1'b1);
        rd("t5_locked_en", WDT_WDEN, 32'd1, 1'b1, 1'b1);
        rd("t5_locked_wtocnt", WDT_WTOCNT, 32'd3, 1'b1, 1'b1);
        rst_pulse("t5_rst_clears_req");
        rd("t5_post_en", WDT_WDEN, 32'd0, 1'b0, 1'b0);
`else
        // No escalation: reset request never rises, interrupt just holds.
        wr("t5_wtocnt", WDT_WTOCNT, 32'd3, 1'b0, 1'b0);
        wr("t5_en", WDT_WDEN, 32'd1, 1'b0, 1'b0);
        for (int i = 1; i <= 100; i++)
            rd("t5_no_rrq", WDT_WDLIVE, (i >= 5) ? 32'd1 : 32'd0, (i >= 5), 1'b0);
`endif

        wdt_we = 1'b0;
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
